image_xform_engine: RTL and testbench
=====================================

# image_xform_engine

Frame-level geometric transform engine between the video frame buffers and the DDR memory controller's burst read and write ports. It copies one frame, segment by segment, from a ping-pong read buffer to a ping-pong write buffer. It applies one of five modes: pass, segment shift, horizontal mirror, vertical mirror, or 180° rotation. Transform settings are latched once per frame, and `frame_done` returns control to the host logic.

## Interface
- MEM_DATA_LEN, 64: memory word width; one word = one pixel group addressed as one unit
- ADDR_LEN, 32: memory address width
- VIDEO_WIDTH, 1024: words per line; must be a multiple of BURST_LEN
- VIDEO_HEIGHT, 768: lines per frame
- BURST_LEN, 8: words per segment/burst, 1..256
- RD_BASE0 / RD_BASE1, 2073600 / 0: read buffer bases for buf_sel 0 / 1
- WR_BASE0 / WR_BASE1, 6220800 / 4147200: write buffer bases for buf_sel 0 / 1
- FILL_VALUE, 0: word written for out-of-frame source pixels
- clk  in  1  memory-domain clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle request to process one frame
- cfg_mode  in  3  0 pass, 1 shift, 2 hmirror, 3 vmirror, 4 rot180, 5-7 treated as pass
- cfg_dx  in  12  signed horizontal shift in segments (+ moves image right)
- cfg_dy  in  12  signed vertical shift in lines (+ moves image down)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end
- buf_sel  out  1  ping-pong select; toggles at each frame_done
- rd_valid  out  1 / rd_ready  in  1 / rd_burst_len  out  10 / rd_addr  out  ADDR_LEN / rd_data  in  MEM_DATA_LEN / rd_burst_finish  in  1
- wr_valid  out  1 / wr_ready  in  1 / wr_burst_len  out  10 / wr_addr  out  ADDR_LEN / wr_data  out  MEM_DATA_LEN / wr_burst_finish  in  1
- error  out  1  sticky burst-protocol error

## Operation
- States: IDLE, SETUP, READ, WRITE, NEXT.
- IDLE: `frame_start` latches cfg_mode, cfg_dx, cfg_dy. It also clears seg (0..W/BL-1) and line (0..H-1), and goes to SETUP. While busy, `frame_start` is ignored; cfg inputs are sampled only at that latch.
- SETUP computes the source segment ss and source line sl. Defaults: ss=seg, sl=line.
  - Shift: ss=seg-dx, sl=line-dy.
  - hmirror: ss=W/BL-1-seg.
  - vmirror: sl=H-1-line.
  - rot180: both mirrors.
  - Signed arithmetic is 13 bits.
  - If ss and sl are both in range: rd_addr = RD_BASEsel + sl*W + ss*BL, rd_valid=1, go to READ.
  - Otherwise: fill=1, wr_valid=1, go to WRITE with no read.
- READ: each cycle with rd_ready=1 stores rd_data into buf[beat] and increments beat. `rd_burst_finish` drops rd_valid, raises wr_valid, and goes to WRITE.
- WRITE: wr_addr = WR_BASEsel + line*W + seg*BL.
  - wr_data is combinational: FILL_VALUE if fill; buf[BL-1-wbeat] in hmirror/rot180; else buf[wbeat].
  - wbeat advances on each wr_ready cycle.
  - `wr_burst_finish` drops wr_valid and goes to NEXT.
- NEXT: seg increments; on wrap, seg=0 and line increments.
  - After the last segment of the last line: frame_done=1, buf_sel toggles, busy=0, go to IDLE.
  - Otherwise go to SETUP.
- rd_burst_len = wr_burst_len = BURST_LEN, constant.
- All address arithmetic is modulo 2^ADDR_LEN.
- error sets when a read delivers a beat count ≠ BL at finish, or a write sees wr_ready beats ≠ BL at finish. Extra read beats are discarded. Processing continues.

## Timing
- Reset values: busy, frame_done, buf_sel, rd_valid, wr_valid, error = 0; rd_addr, wr_addr = 0; rd/wr_burst_len = BURST_LEN; state IDLE.
- Reset mid-frame aborts at the next edge with no completion pulse, and buf_sel returns to 0.
- busy rises the cycle after the `frame_start` is sampled; rd_valid or wr_valid rises 2 cycles after it.
- rd_valid/rd_addr are held stable until the cycle `rd_burst_finish` is seen. The same rule applies to wr_valid/wr_addr with `wr_burst_finish`.
- The write request is issued the cycle after `rd_burst_finish`.
- A beat on the same cycle as finish is still counted and stored.
- Per-segment overhead: 3 cycles (SETUP, handoff, NEXT) plus the controller latency. A fill segment skips the read.
- frame_done is high exactly one cycle, coincident with busy falling.

## Test plan
- W=32, H=4, BL=8, mode 0: buffer holds pixel index.
  - Expect 16 read/write pairs with rd_addr = 2073600 + 8k and wr_addr = 6220800 + 8k.
  - Output equals input; one frame_done; buf_sel = 1.
- Mode 2 (hmirror), same frame: seg 0 of line 1 reads from 2073600+56 and writes words 63..56 reversed to 6220800+32.
- Mode 1 with dx=+1, dy=-1:
  - Line 3 and seg 0 are written FILL_VALUE with no read (rd_valid stays 0 for them).
  - Line 0 seg 1 reads from source line 1 seg 0.
- Mode 4 (rot180): output word (line l, x) equals input (3-l, 31-x) for all 128 words.
- Controller delivers 7 beats before `rd_burst_finish` → error = 1 and stays 1; frame still completes.
- Second `frame_start` mid-frame is ignored. rst asserted at segment 5 → next cycle busy = 0, valids = 0, buf_sel = 0. A new `frame_start` then runs a clean frame.

Source files
------------

// File: rtl/image_xform_engine.sv
// Frame geometric transform engine: copies one frame segment by segment from a
// ping-pong read buffer to a ping-pong write buffer with pass/shift/mirror/rotate addressing.
module image_xform_engine #(
   parameter int MEM_DATA_LEN = 64,
   parameter int ADDR_LEN     = 32,
   parameter int VIDEO_WIDTH  = 1024,
   parameter int VIDEO_HEIGHT = 768,
   parameter int BURST_LEN    = 8,
   parameter logic [ADDR_LEN-1:0]     RD_BASE0   = 2073600,
   parameter logic [ADDR_LEN-1:0]     RD_BASE1   = 0,
   parameter logic [ADDR_LEN-1:0]     WR_BASE0   = 6220800,
   parameter logic [ADDR_LEN-1:0]     WR_BASE1   = 4147200,
   parameter logic [MEM_DATA_LEN-1:0] FILL_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic [2:0]              cfg_mode,
   input  logic [11:0]             cfg_dx,
   input  logic [11:0]             cfg_dy,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    buf_sel,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [9:0]              rd_burst_len,
   output logic [ADDR_LEN-1:0]     rd_addr,
   input  logic [MEM_DATA_LEN-1:0] rd_data,
   input  logic                    rd_burst_finish,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [9:0]              wr_burst_len,
   output logic [ADDR_LEN-1:0]     wr_addr,
   output logic [MEM_DATA_LEN-1:0] wr_data,
   input  logic                    wr_burst_finish,
   output logic                    error
);

   localparam int SEGS   = VIDEO_WIDTH / BURST_LEN;
   localparam int SEG_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam int LINE_W = (VIDEO_HEIGHT > 1) ? $clog2(VIDEO_HEIGHT) : 1;
   localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BEAT_W = $clog2(BURST_LEN + 2);

   localparam logic [SEG_W-1:0]    SEG_LAST    = SEG_W'(SEGS - 1);
   localparam logic [LINE_W-1:0]   LINE_LAST   = LINE_W'(VIDEO_HEIGHT - 1);
   localparam logic [BEAT_W-1:0]   BEATS       = BEAT_W'(BURST_LEN);
   localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(BURST_LEN - 1);
   localparam logic signed [12:0]  SEGS_S      = 13'(SEGS);
   localparam logic signed [12:0]  LINES_S     = 13'(VIDEO_HEIGHT);
   localparam logic [ADDR_LEN-1:0] LINE_STRIDE = ADDR_LEN'(VIDEO_WIDTH);
   localparam logic [ADDR_LEN-1:0] SEG_STRIDE  = ADDR_LEN'(BURST_LEN);

   typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, NEXT} state_t;

   state_t                  state;
   logic [2:0]              mode_q;
   logic signed [11:0]      dx_q, dy_q;
   logic [SEG_W-1:0]        seg;
   logic [LINE_W-1:0]       line;
   logic [BEAT_W-1:0]       beat, wbeat;
   logic                    fill;
   logic [MEM_DATA_LEN-1:0] line_buf [BURST_LEN];

   logic signed [12:0]      seg_s, line_s, dx_e, dy_e, ss, sl;
   logic                    in_range, mirror;
   logic [ADDR_LEN-1:0]     src_off, dst_off, rd_base, wr_base;
   logic [BEAT_W-1:0]       rd_count, wr_count;
   logic [IDX_W-1:0]        widx;

   // Beat counters saturate so an overrunning controller cannot wrap back to a legal count.
   function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
      return (&v) ? v : v + BEAT_W'(1);
   endfunction

   assign rd_burst_len = 10'(BURST_LEN);
   assign wr_burst_len = 10'(BURST_LEN);

   assign seg_s  = 13'(seg);
   assign line_s = 13'(line);
   assign dx_e   = 13'(dx_q);
   assign dy_e   = 13'(dy_q);

   always_comb begin
      ss = seg_s;
      sl = line_s;
      case (mode_q)
         3'd1: begin
            ss = seg_s - dx_e;
            sl = line_s - dy_e;
         end
         3'd2: ss = (SEGS_S - 13'sd1) - seg_s;
         3'd3: sl = (LINES_S - 13'sd1) - line_s;
         3'd4: begin
            ss = (SEGS_S - 13'sd1) - seg_s;
            sl = (LINES_S - 13'sd1) - line_s;
         end
         default: ;
      endcase
   end

   assign in_range = (ss >= 13'sd0) && (ss < SEGS_S) && (sl >= 13'sd0) && (sl < LINES_S);
   assign mirror   = (mode_q == 3'd2) || (mode_q == 3'd4);
   assign rd_base  = buf_sel ? RD_BASE1 : RD_BASE0;
   assign wr_base  = buf_sel ? WR_BASE1 : WR_BASE0;
   assign src_off  = ADDR_LEN'($unsigned(sl)) * LINE_STRIDE + ADDR_LEN'($unsigned(ss)) * SEG_STRIDE;
   assign dst_off  = ADDR_LEN'(line) * LINE_STRIDE + ADDR_LEN'(seg) * SEG_STRIDE;

   // Counts include a beat that lands on the same cycle as the finish strobe.
   assign rd_count = rd_ready ? sat_inc(beat) : beat;
   assign wr_count = wr_ready ? sat_inc(wbeat) : wbeat;

   always_comb begin
      widx = (wbeat < BEATS) ? wbeat[IDX_W-1:0] : IDX_LAST;
      if (mirror) widx = IDX_LAST - widx;
      wr_data = fill ? FILL_VALUE : line_buf[widx];
   end

   always_ff @(posedge clk) begin
      if (state == READ && rd_ready && beat < BEATS) line_buf[beat[IDX_W-1:0]] <= rd_data;
   end

   always_ff @(posedge clk) begin
      frame_done <= 1'b0;
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         buf_sel  <= 1'b0;
         rd_valid <= 1'b0;
         wr_valid <= 1'b0;
         error    <= 1'b0;
         rd_addr  <= '0;
         wr_addr  <= '0;
         fill     <= 1'b0;
         seg      <= '0;
         line     <= '0;
         beat     <= '0;
         wbeat    <= '0;
         mode_q   <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  mode_q <= cfg_mode;
                  dx_q   <= cfg_dx;
                  dy_q   <= cfg_dy;
                  seg    <= '0;
                  line   <= '0;
                  busy   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               beat    <= '0;
               wbeat   <= '0;
               wr_addr <= wr_base + dst_off;
               if (in_range) begin
                  rd_addr  <= rd_base + src_off;
                  rd_valid <= 1'b1;
                  fill     <= 1'b0;
                  state    <= READ;
               end else begin
                  fill     <= 1'b1;
                  wr_valid <= 1'b1;
                  state    <= WRITE;
               end
            end
            READ: begin
               if (rd_ready) beat <= sat_inc(beat);
               if (rd_burst_finish) begin
                  if (rd_count != BEATS) error <= 1'b1;
                  rd_valid <= 1'b0;
                  wr_valid <= 1'b1;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (wr_ready) wbeat <= sat_inc(wbeat);
               if (wr_burst_finish) begin
                  if (wr_count != BEATS) error <= 1'b1;
                  wr_valid <= 1'b0;
                  state    <= NEXT;
               end
            end
            NEXT: begin
               if (seg == SEG_LAST) begin
                  seg <= '0;
                  if (line == LINE_LAST) begin
                     line       <= '0;
                     frame_done <= 1'b1;
                     buf_sel    <= ~buf_sel;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     line  <= line + LINE_W'(1);
                     state <= SETUP;
                  end
               end else begin
                  seg   <= seg + SEG_W'(1);
                  state <= SETUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_xform_engine.sv
// Bench for image_xform_engine: randomized burst controller plus a pixel-level
// reference of each transform, checked on every request and write beat.
module tb_image_xform_engine;

   localparam int W = 32, H = 4, BL = 8, NSEG = W / BL, TOT = NSEG * H;
   localparam int RDB0 = 2073600, RDB1 = 0, WRB0 = 6220800, WRB1 = 4147200;
   localparam logic [63:0] FILL = 64'hF11F_0000_F11F_0000;

   logic        clk, rst, frame_start;
   logic [2:0]  cfg_mode;
   logic [11:0] cfg_dx, cfg_dy;
   logic        busy, frame_done, buf_sel, error;
   logic        rd_valid, rd_ready, rd_burst_finish;
   logic        wr_valid, wr_ready, wr_burst_finish;
   logic [9:0]  rd_burst_len, wr_burst_len;
   logic [31:0] rd_addr, wr_addr;
   logic [63:0] rd_data, wr_data;

   int checks, errors;
   int exp_sel, cur_seg, done_cnt, nframes;
   int wbeat_tb, short_req, short_done;
   bit data_en;
   logic [31:0] cur_wrb;

   logic [63:0] exp_out  [TOT*BL];
   bit          exp_fill [TOT];
   logic [31:0] exp_rd   [TOT];

   image_xform_engine #(
      .MEM_DATA_LEN(64), .ADDR_LEN(32), .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .BURST_LEN(BL),
      .RD_BASE0(RDB0), .RD_BASE1(RDB1), .WR_BASE0(WRB0), .WR_BASE1(WRB1), .FILL_VALUE(FILL)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_mode(cfg_mode),
      .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .busy(busy), .frame_done(frame_done), .buf_sel(buf_sel),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_burst_len(rd_burst_len), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_burst_finish(rd_burst_finish),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_burst_len(wr_burst_len), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_burst_finish(wr_burst_finish), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] src_word(input logic [31:0] a);
      return {a ^ 32'hC3A5_0000, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pixel-level reference: where each output word of the frame comes from.
   task automatic build_model(input int m, input int dx, input int dy, input int sel);
      int rb, sx, sy, idx;
      bit ok;
      logic [31:0] a;
      rb = sel ? RDB1 : RDB0;
      for (int l = 0; l < H; l++) begin
         for (int x = 0; x < W; x++) begin
            sx = x;
            sy = l;
            if (m == 1) begin
               sx = x - dx * BL;
               sy = l - dy;
            end
            if (m == 2 || m == 4) sx = W - 1 - x;
            if (m == 3 || m == 4) sy = H - 1 - l;
            ok  = (sx >= 0) && (sx < W) && (sy >= 0) && (sy < H);
            idx = (l * W + x) / BL;
            a   = 32'(rb + sy * W + sx);
            exp_out[l*W+x] = ok ? src_word(a) : FILL;
            if (x % BL == 0) begin
               exp_fill[idx] = !ok;
               exp_rd[idx]   = a;
            end else if (ok && a < exp_rd[idx]) begin
               exp_rd[idx] = a;
            end
         end
      end
   endtask

   // Memory controller: random latency and ready gaps, finish on the last beat.
   initial begin : responder
      int rbeat, target;
      bit rd_done, wr_done;
      rd_ready = 0; rd_burst_finish = 0; rd_data = '0;
      wr_ready = 0; wr_burst_finish = 0;
      rbeat = 0; rd_done = 0; wr_done = 0; wbeat_tb = 0; short_done = 0;
      forever begin
         @(posedge clk);
         #1;
         rd_ready = 0; rd_burst_finish = 0; wr_ready = 0; wr_burst_finish = 0;
         if (!rd_valid) begin
            rbeat = 0;
            rd_done = 0;
         end else if (!rd_done && $urandom_range(0, 3) != 0) begin
            target   = (short_req > short_done) ? BL - 1 : BL;
            rd_ready = 1;
            rd_data  = src_word(rd_addr + 32'(rbeat));
            rbeat++;
            if (rbeat == target) begin
               rd_burst_finish = 1;
               rd_done = 1;
               if (target < BL) short_done++;
            end
         end
         if (!wr_valid) begin
            wbeat_tb = 0;
            wr_done = 0;
         end else if (!wr_done && $urandom_range(0, 3) != 0) begin
            wr_ready = 1;
            wbeat_tb++;
            if (wbeat_tb == BL) begin
               wr_burst_finish = 1;
               wr_done = 1;
            end
         end
      end
   end

   initial begin : compare
      cur_seg = 0; done_cnt = 0; cur_wrb = 0;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (frame_start && !busy) begin
            cur_seg = 0;
            cur_wrb = exp_sel ? WRB1 : WRB0;
         end
         if (rd_valid && wr_valid) chk("rd_wr_exclusive", 1, 0);
         if (rd_valid) begin
            if (cur_seg >= TOT) chk("rd_seg_range", cur_seg, TOT - 1);
            else if (exp_fill[cur_seg]) chk("rd_on_fill_seg", cur_seg, 64'hFFFF);
            else chk("rd_addr", rd_addr, exp_rd[cur_seg]);
         end
         if (wr_valid) begin
            if (cur_seg >= TOT) chk("wr_seg_range", cur_seg, TOT - 1);
            else begin
               chk("wr_addr", wr_addr, cur_wrb + 32'(cur_seg * BL));
               if (wr_ready && data_en)
                  chk("wr_data", wr_data, exp_out[cur_seg*BL + wbeat_tb - 1]);
            end
            if (wr_burst_finish) cur_seg++;
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_busy_low", busy, 0);
            chk("done_seg_count", cur_seg, TOT);
         end
      end
   end

   task automatic run_frame(input int m, input int dx, input int dy, input bit mid);
      bit got;
      build_model(m, dx, dy, exp_sel);
      chk("buf_sel_pre", buf_sel, exp_sel);
      frame_start = 1;
      cfg_mode = 3'(m);
      cfg_dx = 12'(dx);
      cfg_dy = 12'(dy);
      @(posedge clk);
      #1;
      frame_start = 0;
      cfg_mode = 3'($urandom_range(0, 7));
      cfg_dx = 12'($urandom);
      cfg_dy = 12'($urandom);
      chk("busy_rise", busy, 1);
      chk("valid_early", {rd_valid, wr_valid}, 0);
      @(posedge clk);
      #1;
      chk("first_req", {rd_valid, wr_valid}, exp_fill[0] ? 2'b01 : 2'b10);
      if (mid) begin
         repeat (20) @(posedge clk);
         #1;
         frame_start = 1;
         @(posedge clk);
         #1;
         frame_start = 0;
      end
      got = 0;
      for (int n = 0; n < 5000 && !got; n++) begin
         @(posedge clk);
         #1;
         if (frame_done) got = 1;
      end
      chk("frame_done_seen", got, 1);
      if (got) begin
         nframes++;
         exp_sel ^= 1;
         chk("buf_sel_toggle", buf_sel, exp_sel);
         chk("busy_fall", busy, 0);
      end
      @(posedge clk);
      #1;
      chk("done_one_cycle", frame_done, 0);
      chk("done_count", done_cnt, nframes);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit seen5;
      checks = 0; errors = 0; exp_sel = 0; nframes = 0; short_req = 0; data_en = 1;
      rst = 1; frame_start = 0; cfg_mode = 0; cfg_dx = 0; cfg_dy = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_buf_sel", buf_sel, 0);
      chk("rst_valids", {rd_valid, wr_valid}, 0);
      chk("rst_error", error, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_len", rd_burst_len, BL);
      chk("rst_wr_len", wr_burst_len, BL);
      rst = 0;

      build_model(0, 0, 0, 0);
      chk("pin_m0_rd0", exp_rd[0], 32'd2073600);
      chk("pin_m0_rd15", exp_rd[15], 32'd2073720);
      chk("pin_m0_w37", exp_out[37], 64'hC3BAA425_001FA425);
      build_model(2, 0, 0, 0);
      chk("pin_m2_rd4", exp_rd[4], 32'd2073656);
      chk("pin_m2_w32", exp_out[32], src_word(32'd2073663));
      chk("pin_m2_w39", exp_out[39], src_word(32'd2073656));
      build_model(1, 1, -1, 0);
      chk("pin_m1_fill0", exp_fill[0], 1);
      chk("pin_m1_fill12", exp_fill[12], 1);
      chk("pin_m1_fill1", exp_fill[1], 0);
      chk("pin_m1_rd1", exp_rd[1], 32'd2073632);
      chk("pin_m1_w127", exp_out[127], FILL);
      build_model(4, 0, 0, 0);
      chk("pin_m4_w0", exp_out[0], src_word(32'd2073727));
      chk("pin_m4_w127", exp_out[127], src_word(32'd2073600));

      run_frame(0, 0, 0, 0);
      chk("err_clean", error, 0);
      run_frame(2, 0, 0, 0);
      run_frame(1, 1, -1, 0);
      run_frame(4, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)) - 6,
                   int'($urandom_range(0, 10)) - 5, 0);
      chk("err_after_random", error, 0);

      short_req = 1;
      data_en = 0;
      run_frame(0, 0, 0, 0);
      data_en = 1;
      chk("err_short_read", error, 1);
      run_frame(3, 0, 0, 0);
      chk("err_sticky", error, 1);

      run_frame(0, 0, 0, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("mid_start_idle", busy, 0);
      chk("mid_start_one_done", done_cnt, nframes);

      build_model(0, 0, 0, exp_sel);
      frame_start = 1;
      cfg_mode = 0; cfg_dx = 0; cfg_dy = 0;
      @(posedge clk);
      #1;
      frame_start = 0;
      seen5 = 0;
      for (int n = 0; n < 2000 && !seen5; n++) begin
         @(posedge clk);
         #1;
         if (cur_seg == 5) seen5 = 1;
      end
      chk("reach_seg5", seen5, 1);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valids", {rd_valid, wr_valid}, 0);
      chk("abort_buf_sel", buf_sel, 0);
      chk("abort_done", frame_done, 0);
      chk("abort_error", error, 0);
      exp_sel = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, nframes);
      run_frame(4, 0, 0, 0);
      chk("err_after_abort", error, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
